rs232_avalon_slave: RTL

RS232_AVALON_SLAVE -- requirements
Module: rs232_avalon_slave

---
 rtl/rs232_avalon_slave.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rs232_avalon_slave.sv
// Avalon-MM slave bridging a byte-stream UART core through RX/TX FIFOs.
// Every access costs exactly one wait state; status flags are sticky until read.
module rs232_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module rs232_avalon_slave #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  output logic        avm_waitrequest,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);
  localparam logic [4:0] ADDR_RX = 5'd0;
  localparam logic [4:0] ADDR_TX = 5'd4;
  localparam logic [4:0] ADDR_ST = 5'd8;

  logic        ack_q, ack_d;
  logic        rx_ok_q, rx_ok_d;
  logic        under_q, under_d;
  logic        over_q, over_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rmux;

  logic       req, setup, done;
  logic       rd_rx, rd_st, wr_tx;
  logic [7:0] rx_head;
  logic       rx_empty, rx_full;
  logic       tx_empty, tx_full;
  logic       rx_push, tx_pop;
  logic       unused_wdata;

  assign unused_wdata = ^avm_writedata[31:8];

  assign req   = avm_read | avm_write;
  assign setup = req & ~ack_q;
  assign done  = req & ack_q;

  // write wins when both strobes are high
  assign rd_rx = done & ~avm_write & (avm_address == ADDR_RX);
  assign rd_st = done & ~avm_write & (avm_address == ADDR_ST);
  assign wr_tx = done & avm_write & (avm_address == ADDR_TX);

  assign avm_waitrequest = avm_rst | setup;
  assign avm_readdata    = rdata_q;
  assign o_rx_ready      = ~avm_rst & ~rx_full;
  assign o_tx_valid      = ~avm_rst & ~tx_empty;
  assign rx_push         = i_rx_valid & o_rx_ready;
  assign tx_pop          = o_tx_valid & i_tx_ready;

  rs232_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk_i  (avm_clk),
    .rst_i  (avm_rst),
    .push_i (rx_push),
    .data_i (i_rx_data),
    .pop_i  (rd_rx & rx_ok_q),
    .head_o (rx_head),
    .empty_o(rx_empty),
    .full_o (rx_full)
  );

  rs232_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk_i  (avm_clk),
    .rst_i  (avm_rst),
    .push_i (wr_tx),
    .data_i (avm_writedata[7:0]),
    .pop_i  (tx_pop),
    .head_o (o_tx_data),
    .empty_o(tx_empty),
    .full_o (tx_full)
  );

  always_comb begin
    rmux = '0;
    case (avm_address)
      ADDR_RX: rmux = {24'b0, rx_empty ? 8'h00 : rx_head};
      ADDR_ST: rmux = {24'b0, ~rx_empty, ~tx_full, 4'b0,
                       under_q, over_q};
      default: rmux = '0;
    endcase
  end

  // pop decision follows the snapshot so the returned byte is the popped one
  always_comb begin
    ack_d   = setup;
    rx_ok_d = setup ? ~rx_empty : rx_ok_q;
    rdata_d = rdata_q;
    if (setup) rdata_d = avm_write ? 32'h0 : rmux;
    under_d = (rd_rx & ~rx_ok_q) | (under_q & ~rd_st);
    over_d  = (wr_tx & tx_full) | (over_q & ~rd_st);
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      ack_q   <= 1'b0;
      rx_ok_q <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      rx_ok_q <= rx_ok_d;
      under_q <= under_d;
      over_q  <= over_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
